// File: rtl/execute_stage.sv
// Execute stage: single-cycle ALU ops plus an iterative shift-add MUL,
// registered result bundle for write-back and the NZCV flag register.
module execute_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [2:0]       ALUControl,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [WIDTH-1:0] WD_in,
  input  logic             MemWrite_in,
  input  logic             MemtoReg_in,
  input  logic             FlagWrite,
  output logic             busy,
  output logic             out_valid,
  output logic [WIDTH-1:0] ALUResult,
  output logic [WIDTH-1:0] WD,
  output logic             MemWrite,
  output logic             MemtoReg,
  output logic [3:0]       Flags
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic {IDLE, MUL} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] mcand, mplier, acc, acc_n;
  logic [WIDTH-1:0] alu_res, opb;
  logic [WIDTH:0]   sum;
  logic [CW-1:0]    count;
  logic             memwrite_q, fw_q;
  logic             accept, is_mul, is_sub;
  logic             arith, mul_done;
  logic             alu_c, alu_v;

  assign accept   = in_valid & ~busy;
  assign is_mul   = ALUControl == 3'b101;
  assign is_sub   = ALUControl == 3'b001;
  assign arith    = ALUControl == 3'b000 || is_sub;
  assign mul_done = state == MUL && count == CW'(WIDTH - 1);
  assign acc_n    = mplier[0] ? acc + mcand : acc;
  assign MemWrite = memwrite_q & out_valid;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (accept && is_mul) state_n = MUL;
      MUL:  if (mul_done)         state_n = IDLE;
    endcase
  end

  always_comb begin
    busy = state == MUL;
  end

  // SUB is A + ~B + 1; V compares A against the inverted operand
  always_comb begin
    opb   = is_sub ? ~SrcB : SrcB;
    sum   = {1'b0, SrcA} + {1'b0, opb}
          + {{WIDTH{1'b0}}, is_sub};
    alu_c = sum[WIDTH];
    alu_v = (SrcA[WIDTH-1] == opb[WIDTH-1])
          && (sum[WIDTH-1] != SrcA[WIDTH-1]);
    alu_res = '0;
    unique case (ALUControl)
      3'b000: alu_res = sum[WIDTH-1:0];
      3'b001: alu_res = sum[WIDTH-1:0];
      3'b010: alu_res = SrcA & SrcB;
      3'b011: alu_res = SrcA | SrcB;
      3'b100: alu_res = SrcA ^ SrcB;
      3'b101: alu_res = '0;
      3'b110: alu_res = SrcB;
      3'b111: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      ALUResult  <= '0;
      WD         <= '0;
      MemtoReg   <= 1'b0;
      memwrite_q <= 1'b0;
      fw_q       <= 1'b0;
      Flags      <= 4'b0000;
      mcand      <= '0;
      mplier     <= '0;
      acc        <= '0;
      count      <= '0;
    end else begin
      out_valid <= 1'b0;
      if (accept) begin
        WD         <= WD_in;
        MemtoReg   <= MemtoReg_in;
        memwrite_q <= MemWrite_in;
        fw_q       <= FlagWrite;
        if (is_mul) begin
          mcand  <= SrcA;
          mplier <= SrcB;
          acc    <= '0;
          count  <= '0;
        end else begin
          ALUResult <= alu_res;
          out_valid <= 1'b1;
          if (FlagWrite && ALUControl != 3'b111) begin
            Flags[3] <= alu_res[WIDTH-1];
            Flags[2] <= alu_res == '0;
            if (arith) Flags[1:0] <= {alu_c, alu_v};
          end
        end
      end else if (state == MUL) begin
        acc    <= acc_n;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        count  <= count + CW'(1);
        if (mul_done) begin
          ALUResult <= acc_n;
          out_valid <= 1'b1;
          if (fw_q) Flags[3:2] <= {acc_n[WIDTH-1], acc_n == '0};
        end
      end
    end
  end

endmodule
